// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - handshaked ALU control decoder with optional serial shift expansion
module alu_ctrl_seq #(
    parameter int OP_W        = 4,
    parameter int SHAMT_W     = 5,
    parameter int MULTI_SHIFT = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    alu_op,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               b_inv,
    output logic               cin,
    output logic [1:0]         s,
    output logic [1:0]         m,
    output logic [1:0]         shift,
    output logic [1:0]         sel,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               illegal
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state, state_nxt;
    logic [SHAMT_W-1:0] rem, rem_nxt, rem_d;
    logic [SHAMT_W-1:0] osh_q, osh_nxt, osh_d;
    // {illegal, b_inv, cin, s, m, shift, sel}
    logic [10:0]        ctrl_q, ctrl_nxt, ctrl_d;

    logic       d_illegal, d_b_inv, d_cin, is_shift;
    logic [1:0] d_s, d_m, d_shift, d_sel;
    logic       accept, beat_done, last_done;

    assign out_valid = (state == EMIT);
    assign out_last  = (rem == SHAMT_W'(1));
    assign in_ready  = !out_valid || (out_ready && out_last);
    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;
    assign last_done = beat_done && out_last;

    assign {illegal, b_inv, cin, s, m, shift, sel} = ctrl_q;
    assign out_shamt = osh_q;

    always_comb begin
        d_illegal = 1'b0;
        d_b_inv   = 1'b0;
        d_cin     = 1'b0;
        d_s       = 2'd0;
        d_m       = 2'd0;
        d_shift   = 2'd0;
        d_sel     = 2'd0;
        is_shift  = 1'b0;
        if (alu_op >= OP_W'(12)) begin
            d_illegal = 1'b1;
        end else begin
            case (alu_op[3:0])
                4'd0: d_s = 2'd1;
                4'd1: begin d_b_inv = 1'b1; d_cin = 1'b1; d_s = 2'd1; end
                4'd2: begin d_s = 2'd2; is_shift = 1'b1; end
                4'd3: begin d_s = 2'd2; d_shift = 2'd1; is_shift = 1'b1; end
                4'd4: begin d_s = 2'd2; d_shift = 2'd2; is_shift = 1'b1; end
                4'd6: d_sel = 2'd1;
                4'd7: d_sel = 2'd2;
                4'd8, 4'd9, 4'd10, 4'd11: begin
                    d_b_inv = 1'b1;
                    d_cin   = 1'b1;
                    d_s     = 2'd3;
                    d_m     = alu_op[1:0];
                end
                default: ;
            endcase
        end
        ctrl_d = {d_illegal, d_b_inv, d_cin, d_s, d_m, d_shift, d_sel};

        // shamt=0 still needs one beat to carry the no-op shift to the ALU
        if (is_shift && (MULTI_SHIFT != 0)) begin
            rem_d = (shamt == '0) ? SHAMT_W'(1) : shamt;
            osh_d = (shamt == '0) ? '0 : SHAMT_W'(1);
        end else begin
            rem_d = SHAMT_W'(1);
            osh_d = is_shift ? shamt : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        osh_nxt   = osh_q;
        ctrl_nxt  = ctrl_q;
        if (accept) begin
            state_nxt = EMIT;
            rem_nxt   = rem_d;
            osh_nxt   = osh_d;
            ctrl_nxt  = ctrl_d;
        end else if (last_done) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
            osh_nxt   = '0;
            ctrl_nxt  = '0;
        end else if (beat_done) begin
            rem_nxt   = rem - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rem    <= '0;
            osh_q  <= '0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            osh_q  <= osh_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed table-driven bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] alu_op = '0;
    logic [4:0] shamt = '0;
    logic       out_ready = 1'b1;

    logic       in_ready, out_valid, out_last, b_inv, cin, illegal;
    logic [1:0] s, m, shift, sel;
    logic [4:0] out_shamt;

    logic       in_ready0, out_valid0, out_last0, b_inv0, cin0, illegal0;
    logic [1:0] s0, m0, shift0, sel0;
    logic [4:0] out_shamt0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    alu_ctrl_seq #(.OP_W(4), .SHAMT_W(5), .MULTI_SHIFT(1)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .b_inv(b_inv), .cin(cin), .s(s), .m(m), .shift(shift),
        .sel(sel), .out_shamt(out_shamt), .illegal(illegal)
    );

    alu_ctrl_seq #(.OP_W(4), .SHAMT_W(5), .MULTI_SHIFT(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_op(alu_op), .shamt(shamt), .out_valid(out_valid0), .out_ready(out_ready),
        .out_last(out_last0), .b_inv(b_inv0), .cin(cin0), .s(s0), .m(m0), .shift(shift0),
        .sel(sel0), .out_shamt(out_shamt0), .illegal(illegal0)
    );

    // {b_inv, cin, s, m, shift, sel, out_shamt, out_last, illegal, out_valid}
    logic [17:0] act, act0;
    assign act  = {b_inv, cin, s, m, shift, sel, out_shamt, out_last, illegal, out_valid};
    assign act0 = {b_inv0, cin0, s0, m0, shift0, sel0, out_shamt0, out_last0, illegal0, out_valid0};

    function automatic logic [17:0] mk(input logic bi, input logic ci, input logic [1:0] fs,
                                       input logic [1:0] fm, input logic [1:0] fsh,
                                       input logic [1:0] fse, input logic [4:0] os,
                                       input logic last, input logic ill);
        return {bi, ci, fs, fm, fsh, fse, os, last, ill, 1'b1};
    endfunction

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'd0,  5'd0, mk(0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[1]  = '{4'd1,  5'd0, mk(1, 1, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[2]  = '{4'd2,  5'd1, mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 5'd1, 1, 0)};
        vecs[3]  = '{4'd3,  5'd1, mk(0, 0, 2'd2, 2'd0, 2'd1, 2'd0, 5'd1, 1, 0)};
        vecs[4]  = '{4'd4,  5'd1, mk(0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 5'd1, 1, 0)};
        vecs[5]  = '{4'd5,  5'd7, mk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[6]  = '{4'd6,  5'd0, mk(0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 5'd0, 1, 0)};
        vecs[7]  = '{4'd7,  5'd0, mk(0, 0, 2'd0, 2'd0, 2'd0, 2'd2, 5'd0, 1, 0)};
        vecs[8]  = '{4'd8,  5'd0, mk(1, 1, 2'd3, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[9]  = '{4'd9,  5'd0, mk(1, 1, 2'd3, 2'd1, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[10] = '{4'd10, 5'd0, mk(1, 1, 2'd3, 2'd2, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[11] = '{4'd11, 5'd0, mk(1, 1, 2'd3, 2'd3, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[12] = '{4'd13, 5'd3, mk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1, 1)};
        vecs[13] = '{4'd0,  5'd0, mk(0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};
        vecs[14] = '{4'd2,  5'd0, mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0)};

        // reset state
        #2;
        chk("reset_outputs", act, 18'd0);
        chk1("reset_in_ready", in_ready, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        // back-to-back decode table
        for (int i = 0; i < 15; i++) begin
            if (i > 0) chk($sformatf("vec%0d", i - 1), act, vecs[i - 1].exp);
            in_valid = 1'b1;
            alu_op   = vecs[i].op;
            shamt    = vecs[i].sh;
            @(negedge clock);
        end
        chk("vec14", act, vecs[14].exp);
        in_valid = 1'b0;
        @(negedge clock);
        chk("idle_after_table", act, 18'd0);

        // serial SRA, shamt=5
        in_valid = 1'b1; alu_op = 4'd4; shamt = 5'd5;
        @(negedge clock);
        in_valid = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            chk($sformatf("sra_beat%0d", b), act,
                mk(0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 5'd1, (b == 5), 0));
            chk1($sformatf("sra_in_ready%0d", b), in_ready, (b == 5));
            @(negedge clock);
        end
        chk("idle_after_sra", act, 18'd0);

        // backpressure on LT while ADD is requested
        in_valid = 1'b1; alu_op = 4'd10; shamt = 5'd0;
        @(negedge clock);
        alu_op = 4'd0;
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b0;
            #1;
            chk($sformatf("lt_hold%0d", c), act, mk(1, 1, 2'd3, 2'd2, 2'd0, 2'd0, 5'd0, 1, 0));
            chk1($sformatf("lt_hold_in_ready%0d", c), in_ready, 1'b0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk("add_after_hold", act, mk(0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0));
        @(negedge clock);
        chk("idle_after_hold", act, 18'd0);

        // async reset on beat 2 of SRL shamt=4
        in_valid = 1'b1; alu_op = 4'd3; shamt = 5'd4;
        @(negedge clock);
        in_valid = 1'b0;
        chk("srl_beat1", act, mk(0, 0, 2'd2, 2'd0, 2'd1, 2'd0, 5'd1, 0, 0));
        @(negedge clock);
        chk("srl_beat2", act, mk(0, 0, 2'd2, 2'd0, 2'd1, 2'd0, 5'd1, 0, 0));
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_clear", act, 18'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk($sformatf("no_residual%0d", c), act, 18'd0);
        end
        in_valid = 1'b1; alu_op = 4'd1; shamt = 5'd0;
        @(negedge clock);
        in_valid = 1'b0;
        chk("sub_after_reset", act, mk(1, 1, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0));
        chk("sub_after_reset_ms0", act0, mk(1, 1, 2'd1, 2'd0, 2'd0, 2'd0, 5'd0, 1, 0));
        @(negedge clock);

        // max shamt: single beat when MULTI_SHIFT=0, exactly 31 beats otherwise
        in_valid = 1'b1; alu_op = 4'd2; shamt = 5'd31;
        @(negedge clock);
        in_valid = 1'b0;
        chk("sll31_ms0", act0, mk(0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 5'd31, 1, 0));
        begin
            int beats;
            int lasts;
            beats = 0;
            lasts = 0;
            for (int c = 0; c < 40 && out_valid; c++) begin
                beats++;
                if (out_last) lasts++;
                if (c == 1) chk("sll31_ms0_idle", act0, 18'd0);
                if (out_last) chk1("sll31_last_beat31", beats == 31, 1'b1);
                @(negedge clock);
            end
            chk1("sll31_beat_count", beats == 31, 1'b1);
            chk1("sll31_single_last", lasts == 1, 1'b1);
            chk("sll31_idle", act, 18'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
